// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: rotates active-low column drive, builds a 16-bit frame of
// closed keys, debounces single presses/releases and shifts accepted codes into value.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 200000,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] value
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t           state, state_n;
    logic [3:0]       row_meta, row_sync;
    logic [DIV_W-1:0] div;
    logic [1:0]       c;
    logic [15:0]      frame, frame_cap;
    logic             tick, frame_end;
    logic [3:0]       cnt, cnt_n, cand, cand_n, code_n, single_k;
    logic             valid_n, held_n;
    logic [15:0]      value_n;
    logic [4:0]       ones;
    logic             is_empty, is_single;
    logic             do_accept, do_release;
    logic [3:0]       acc_k;
    logic [3:0]       cnt_inc;

    assign tick      = (div == DIV_LAST);
    assign frame_end = tick && (c == 2'd3);
    assign cnt_inc   = cnt + 4'd1;

    // Row synchronizer, scan divider and column rotation
    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta <= 4'b1111;
            row_sync <= 4'b1111;
            div      <= '0;
            c        <= 2'd0;
            col      <= 4'b1110;
            frame    <= '0;
        end else begin
            row_meta <= row;
            row_sync <= row_meta;
            if (tick) begin
                div   <= '0;
                c     <= c + 2'd1;
                col   <= ~(4'b0001 << (c + 2'd1));
                frame <= frame_cap;
            end else begin
                div <= div + DIV_W'(1);
            end
        end
    end

    // Frame with the current column's sample merged in
    always_comb begin
        frame_cap = frame;
        for (int r = 0; r < 4; r++) begin
            frame_cap[{2'(r), c}] = ~row_sync[r];
        end
    end

    always_comb begin
        ones     = 5'd0;
        single_k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (frame_cap[i]) begin
                ones     = ones + 5'd1;
                single_k = 4'(i);
            end
        end
        is_empty  = (ones == 5'd0);
        is_single = (ones == 5'd1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Debounce FSM, evaluated only at frame end
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        cand_n     = cand;
        code_n     = key_code;
        valid_n    = 1'b0;
        held_n     = key_held;
        value_n    = value;
        do_accept  = 1'b0;
        do_release = 1'b0;
        acc_k      = cand;
        if (frame_end) begin
            case (state)
                IDLE: begin
                    if (is_single) begin
                        cand_n = single_k;
                        cnt_n  = 4'd1;
                        acc_k  = single_k;
                        if (DEB == 4'd1) do_accept = 1'b1;
                        else             state_n   = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (is_single && single_k == cand) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB) do_accept = 1'b1;
                    end else if (is_single) begin
                        cand_n = single_k;
                        cnt_n  = 4'd1;
                    end else begin
                        state_n = IDLE;
                    end
                end
                HELD: begin
                    if (is_empty) begin
                        cnt_n = 4'd1;
                        if (DEB == 4'd1) do_release = 1'b1;
                        else             state_n    = RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (is_empty) begin
                        cnt_n = cnt_inc;
                        if (cnt_inc == DEB) do_release = 1'b1;
                    end else begin
                        state_n = HELD;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (do_accept) begin
            code_n  = acc_k;
            valid_n = 1'b1;
            value_n = {value[11:0], acc_k};
            held_n  = 1'b1;
            state_n = HELD;
        end
        if (do_release) begin
            held_n  = 1'b0;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= 4'd0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            value     <= 16'h0000;
        end else begin
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_held  <= held_n;
            value     <= value_n;
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=2 (16-cycle frames).
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] value;

    logic [15:0] keys;
    int          n_vec = 0;
    int          n_err = 0;
    int          pulses;
    int          first_at;
    logic [3:0]  last_code;

    keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .value     (value)
    );

    always #5 clk = ~clk;

    // Keypad matrix model: a closed key pulls its row low while its column is driven
    always_comb begin
        row = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
    end

    // Apply a key set from a frame start for nf frames, recording key_valid pulses
    task automatic run_frames(input logic [15:0] k, input int nf);
        keys     = k;
        pulses   = 0;
        first_at = -1;
        for (int i = 1; i <= nf * 16; i++) begin
            @(posedge clk); #1;
            if (key_valid) begin
                pulses++;
                if (first_at < 0) first_at = i;
                last_code = key_code;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        do_reset();
        n_vec++; if (col !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b expected %b", col, 4'b1110); end
        n_vec++; if (key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
        n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b expected 0", key_held); end
        n_vec++; if (value !== 16'h0000) begin n_err++; $display("FAIL reset_value: got %h expected 0000", value); end
        n_vec++; if (key_code !== 4'h0) begin n_err++; $display("FAIL reset_code: got %h expected 0", key_code); end
        for (int i = 0; i < 16; i++) begin
            exp_col = ~(4'b0001 << (i / 4));
            n_vec++; if (col !== exp_col) begin n_err++; $display("FAIL col_rotate[%0d]: got %b expected %b", i, col, exp_col); end
            @(posedge clk); #1;
        end
        repeat (6) begin @(posedge clk); #1; end
        n_vec++; if (col !== 4'b1101) begin n_err++; $display("FAIL col_midscan: got %b expected %b", col, 4'b1101); end
        do_reset();
        n_vec++; if (col !== 4'b1110) begin n_err++; $display("FAIL reset_midscan_col: got %b expected %b", col, 4'b1110); end
    endtask

    task automatic test_single_press();
        run_frames(16'h0001 << 6, 2);
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL press6_pulses: got %0d expected 1", pulses); end
        n_vec++; if (first_at !== 32) begin n_err++; $display("FAIL press6_latency: got %0d expected 32", first_at); end
        n_vec++; if (key_code !== 4'h6) begin n_err++; $display("FAIL press6_code: got %h expected 6", key_code); end
        n_vec++; if (value !== 16'h0006) begin n_err++; $display("FAIL press6_value: got %h expected 0006", value); end
        n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL press6_held: got %b expected 1", key_held); end
        keys = 16'h0000;
        repeat (31) begin @(posedge clk); #1; end
        n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL release6_early: got %b expected 1", key_held); end
        @(posedge clk); #1;
        n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL release6_held: got %b expected 0", key_held); end
        n_vec++; if (key_code !== 4'h6 || value !== 16'h0006) begin n_err++; $display("FAIL release6_retain: got %h/%h expected 6/0006", key_code, value); end
    endtask

    task automatic test_reset_held();
        run_frames(16'h0001 << 6, 3);
        n_vec++; if (key_held !== 1'b1) begin n_err++; $display("FAIL rh_held_before: got %b expected 1", key_held); end
        do_reset();
        n_vec++; if (key_held !== 1'b0 || value !== 16'h0000) begin n_err++; $display("FAIL rh_cleared: got %b/%h expected 0/0000", key_held, value); end
        run_frames(16'h0001 << 6, 2);
        n_vec++; if (pulses !== 1 || first_at !== 32) begin n_err++; $display("FAIL rh_redebounce: got %0d@%0d expected 1@32", pulses, first_at); end
        run_frames(16'h0000, 2);
        n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL rh_release: got %b expected 0", key_held); end
    endtask

    task automatic test_sequence();
        logic [3:0] codes [5] = '{4'h1, 4'h2, 4'hA, 4'hF, 4'h3};
        for (int j = 0; j < 5; j++) begin
            run_frames(16'h0001 << codes[j], 2);
            n_vec++; if (pulses !== 1 || last_code !== codes[j]) begin n_err++; $display("FAIL seq_key[%0d]: got %0d pulses code %h expected 1 code %h", j, pulses, last_code, codes[j]); end
            run_frames(16'h0000, 2);
            if (j == 3) begin
                n_vec++; if (value !== 16'h12AF) begin n_err++; $display("FAIL seq_value4: got %h expected 12af", value); end
            end
        end
        n_vec++; if (value !== 16'h2AF3) begin n_err++; $display("FAIL seq_value5: got %h expected 2af3", value); end
    endtask

    task automatic test_bounce();
        int total;
        run_frames(16'h0001 << 5, 1); total = pulses;
        run_frames(16'h0000, 1);      total += pulses;
        run_frames(16'h0001 << 5, 2); total += pulses;
        n_vec++; if (total !== 1 || first_at !== 32) begin n_err++; $display("FAIL bounce_events: got %0d@%0d expected 1@32", total, first_at); end
        n_vec++; if (key_code !== 4'h5) begin n_err++; $display("FAIL bounce_code: got %h expected 5", key_code); end
        run_frames(16'h0000, 2);
    endtask

    task automatic test_candidate();
        int total;
        run_frames(16'h0001 << 4, 1); total = pulses;
        run_frames(16'h0001 << 9, 2); total += pulses;
        n_vec++; if (total !== 1 || key_code !== 4'h9) begin n_err++; $display("FAIL cand_switch: got %0d events code %h expected 1 code 9", total, key_code); end
        run_frames(16'h0000, 2);
        run_frames(16'h0210, 3);
        n_vec++; if (pulses !== 0 || key_held !== 1'b0) begin n_err++; $display("FAIL multi_idle: got %0d events held %b expected 0 held 0", pulses, key_held); end
        run_frames(16'h0000, 1);
        n_vec++; if (value !== 16'hF359) begin n_err++; $display("FAIL cand_value: got %h expected f359", value); end
    endtask

    task automatic test_held();
        int total;
        run_frames(16'h4000, 3);  total = pulses;
        run_frames(16'h4001, 7);  total += pulses;
        n_vec++; if (total !== 1 || key_code !== 4'hE) begin n_err++; $display("FAIL held_one_event: got %0d events code %h expected 1 code e", total, key_code); end
        run_frames(16'h0001, 3);
        n_vec++; if (pulses !== 0 || key_held !== 1'b1) begin n_err++; $display("FAIL held_partial_release: got %0d events held %b expected 0 held 1", pulses, key_held); end
        run_frames(16'h0000, 2);
        n_vec++; if (key_held !== 1'b0) begin n_err++; $display("FAIL held_full_release: got %b expected 0", key_held); end
        run_frames(16'h0001, 2);
        n_vec++; if (pulses !== 1 || key_code !== 4'h0) begin n_err++; $display("FAIL held_new_press: got %0d events code %h expected 1 code 0", pulses, key_code); end
        n_vec++; if (value !== 16'h59E0) begin n_err++; $display("FAIL held_value: got %h expected 59e0", value); end
        run_frames(16'h0000, 2);
    endtask

    initial begin
        keys      = 16'h0000;
        reset     = 1'b0;
        last_code = 4'h0;
        test_reset();
        test_single_press();
        test_reset_held();
        test_sequence();
        test_bounce();
        test_candidate();
        test_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
